// File: rtl/adm_hotswap_pkg.sv
// Shared types and register defaults for the ADM1278/ADM1176 hot-swap I2C slave model.
// Holds the FSM state encoding, PMBus command codes and the power-on register image.
package adm_hotswap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_ADDR_ACK = 3'd2,
        ST_WR_BYTE  = 3'd3,
        ST_WR_ACK   = 3'd4,
        ST_RD_BYTE  = 3'd5,
        ST_RD_ACK   = 3'd6
    } state_t;

    localparam logic [7:0]  CMD_READ_VIN    = 8'h88;
    localparam logic [7:0]  CMD_READ_VOUT   = 8'h8B;
    localparam logic [7:0]  CMD_READ_IOUT   = 8'h8C;
    localparam logic [7:0]  CMD_READ_TEMP_1 = 8'h8D;

    localparam logic [15:0] DEF_READ_VIN    = 16'h0A00;
    localparam logic [15:0] DEF_READ_VOUT   = 16'h0A00;
    localparam logic [15:0] DEF_READ_IOUT   = 16'h0100;
    localparam logic [15:0] DEF_READ_TEMP_1 = 16'h0300;

    localparam logic [11:0] ADM1176_V_DEF   = 12'hA00;
    localparam logic [11:0] ADM1176_I_DEF   = 12'h100;

    function automatic logic [15:0] reg_default(input logic [7:0] cmd);
        case (cmd)
            CMD_READ_VIN:    reg_default = DEF_READ_VIN;
            CMD_READ_VOUT:   reg_default = DEF_READ_VOUT;
            CMD_READ_IOUT:   reg_default = DEF_READ_IOUT;
            CMD_READ_TEMP_1: reg_default = DEF_READ_TEMP_1;
            default:         reg_default = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/adm_i2c_bus_monitor.sv
// I2C bus front end: 2-flop synchronizers, SCL edge strobes and START/STOP detection.
// Latency: strobes valid 2 clk after the bus changes, acted on by the next edge; no backpressure.
module adm_i2c_bus_monitor (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    // [0] and [1] are the synchronizer, [2] is the delayed copy used for edge detection
    logic [2:0] r_scl_sh;
    logic [2:0] r_sda_sh;
    logic       w_scl_high;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scl_sh <= 3'b111;
            r_sda_sh <= 3'b111;
        end else begin
            r_scl_sh <= {r_scl_sh[1:0], i_scl};
            r_sda_sh <= {r_sda_sh[1:0], i_sda};
        end
    end

    assign w_scl_high = r_scl_sh[1] & r_scl_sh[2];

    assign o_sda      = r_sda_sh[1];
    assign o_scl_rise = r_scl_sh[1] & ~r_scl_sh[2];
    assign o_scl_fall = ~r_scl_sh[1] & r_scl_sh[2];
    assign o_start    = w_scl_high & r_sda_sh[2] & ~r_sda_sh[1];
    assign o_stop     = w_scl_high & ~r_sda_sh[2] & r_sda_sh[1];

endmodule

// File: rtl/adm_hotswap_model.sv
// Behavioural I2C slave model of an ADM1278 (PMBus words) or ADM1176 (3-byte readout).
// Decisions land 3 clk after the bus changes; SCL is never stretched.
module adm_hotswap_model #(
    parameter logic [6:0] I2C_ADR = 7'h10,
    parameter              DEVICE = "ADM1278",
    parameter              NAME   = "adm"
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_t,
    output logic scl_t
);
    import adm_hotswap_pkg::*;

    localparam bit IS_1176 = (DEVICE == "ADM1176");

    logic        w_sda;
    logic        w_scl_rise;
    logic        w_scl_fall;
    logic        w_start;
    logic        w_stop;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sda_t;
    logic        w_sda_t_nxt;
    logic        w_load_rd;
    logic        w_wr_done;

    logic [3:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_rw;
    logic        r_mack;
    logic        r_first;
    logic [7:0]  r_ptr;
    logic [1:0]  r_idx;
    logic [15:0] r_regs [256];
    logic [15:0] w_reg_rd;
    logic [7:0]  w_rd_byte;

    adm_i2c_bus_monitor u_mon (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (scl_i),
        .i_sda      (sda_i),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign scl_t = 1'b1;
    assign sda_t = r_sda_t;

    always_comb begin
        w_reg_rd  = r_regs[r_ptr];
        w_rd_byte = r_idx[0] ? w_reg_rd[15:8] : w_reg_rd[7:0];
        if (IS_1176) begin
            case (r_idx)
                2'd0:    w_rd_byte = ADM1176_V_DEF[11:4];
                2'd1:    w_rd_byte = ADM1176_I_DEF[11:4];
                2'd2:    w_rd_byte = {ADM1176_V_DEF[3:0], ADM1176_I_DEF[3:0]};
                default: w_rd_byte = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sda_t <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sda_t <= w_sda_t_nxt;
        end
    end

    // SDA only moves on an SCL falling edge, except START/STOP which always release it
    always_comb begin
        w_state_nxt = r_state;
        w_sda_t_nxt = r_sda_t;
        w_load_rd   = 1'b0;
        w_wr_done   = 1'b0;
        if (w_start) begin
            w_state_nxt = ST_ADDR;
            w_sda_t_nxt = 1'b1;
        end else if (w_stop) begin
            w_state_nxt = ST_IDLE;
            w_sda_t_nxt = 1'b1;
        end else if (w_scl_fall) begin
            case (r_state)
                ST_ADDR: begin
                    if (r_bit_cnt == 4'd8) begin
                        if (r_shift[7:1] == I2C_ADR) begin
                            w_state_nxt = ST_ADDR_ACK;
                            w_sda_t_nxt = 1'b0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (r_rw) begin
                        w_state_nxt = ST_RD_BYTE;
                        w_load_rd   = 1'b1;
                        w_sda_t_nxt = w_rd_byte[7];
                    end else begin
                        w_state_nxt = ST_WR_BYTE;
                        w_sda_t_nxt = 1'b1;
                    end
                end
                ST_WR_BYTE: begin
                    if (r_bit_cnt == 4'd8) begin
                        w_state_nxt = ST_WR_ACK;
                        w_sda_t_nxt = 1'b0;
                        w_wr_done   = 1'b1;
                    end
                end
                ST_WR_ACK: begin
                    w_state_nxt = ST_WR_BYTE;
                    w_sda_t_nxt = 1'b1;
                end
                ST_RD_BYTE: begin
                    if (r_bit_cnt == 4'd8) begin
                        w_state_nxt = ST_RD_ACK;
                        w_sda_t_nxt = 1'b1;
                    end else begin
                        w_sda_t_nxt = r_shift[6];
                    end
                end
                ST_RD_ACK: begin
                    if (!r_mack) begin
                        w_state_nxt = ST_RD_BYTE;
                        w_load_rd   = 1'b1;
                        w_sda_t_nxt = w_rd_byte[7];
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_sda_t_nxt = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_rw      <= 1'b0;
            r_mack    <= 1'b1;
            r_first   <= 1'b0;
            r_ptr     <= '0;
            r_idx     <= '0;
            for (int k = 0; k < 256; k++) begin
                r_regs[k] <= reg_default(8'(k));
            end
        end else if (w_start) begin
            r_bit_cnt <= '0;
            r_idx     <= '0;
        end else begin
            if (w_scl_rise) begin
                if (r_state == ST_ADDR || r_state == ST_WR_BYTE) begin
                    r_shift   <= {r_shift[6:0], w_sda};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                if (r_state == ST_RD_ACK) begin
                    r_mack <= w_sda;
                end
            end
            if (w_scl_fall) begin
                case (r_state)
                    ST_ADDR: begin
                        if (r_bit_cnt == 4'd8) r_rw <= r_shift[0];
                    end
                    ST_ADDR_ACK: begin
                        r_bit_cnt <= '0;
                        if (!r_rw) r_first <= 1'b1;
                    end
                    ST_WR_ACK: r_bit_cnt <= '0;
                    ST_RD_BYTE: begin
                        if (r_bit_cnt != 4'd8) begin
                            r_shift   <= {r_shift[6:0], 1'b0};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                    default: ;
                endcase
            end
            if (w_load_rd) begin
                r_shift   <= w_rd_byte;
                r_bit_cnt <= 4'd1;
                if (IS_1176) r_idx <= (r_idx == 2'd3) ? 2'd3 : r_idx + 2'd1;
                else         r_idx <= r_idx + 2'd1;
            end
            // First byte after a write address is the command pointer; the rest are data
            if (w_wr_done) begin
                if (r_first) begin
                    r_ptr   <= r_shift;
                    r_idx   <= '0;
                    r_first <= 1'b0;
                end else begin
                    if (!IS_1176) begin
                        if (r_idx[0]) r_regs[r_ptr][15:8] <= r_shift;
                        else          r_regs[r_ptr][7:0]  <= r_shift;
                    end
                    r_idx <= {1'b0, ~r_idx[0]};
                end
            end
        end
    end

`ifndef SYNTHESIS
    logic        r_log_act;
    logic [31:0] r_log_dat;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_log_act <= 1'b0;
            r_log_dat <= '0;
        end else begin
            if (r_state == ST_ADDR && w_state_nxt == ST_ADDR_ACK) r_log_act <= 1'b1;
            if (w_wr_done && !r_first) r_log_dat <= {r_log_dat[23:0], r_shift};
            if (w_load_rd)             r_log_dat <= {r_log_dat[23:0], w_rd_byte};
            if (w_stop && r_log_act) begin
                $display("%0s: %0s cmd %02h data %08h", NAME, r_rw ? "read " : "write", r_ptr, r_log_dat);
                r_log_act <= 1'b0;
                r_log_dat <= '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adm_hotswap_model.sv
// Directed bench: one ADM1278 (0x10) and one ADM1176 (0x48) on a shared wired-AND I2C bus.
module tb_adm_hotswap_model;
    import adm_hotswap_pkg::*;

    localparam int Q = 8;

    logic clk = 1'b0;
    logic rst;
    logic m_scl;
    logic m_sda;
    logic bus_sda;
    logic sda_t_a, scl_t_a, sda_t_b, scl_t_b;

    int n_vec  = 0;
    int n_fail = 0;

    logic mon_en = 1'b0;
    logic saw_low_a;

    always #5 clk = ~clk;

    assign bus_sda = m_sda & sda_t_a & sda_t_b;

    adm_hotswap_model #(.I2C_ADR(7'h10), .DEVICE("ADM1278"), .NAME("adm")) u_a (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(bus_sda), .sda_t(sda_t_a), .scl_t(scl_t_a)
    );

    adm_hotswap_model #(.I2C_ADR(7'h48), .DEVICE("ADM1176"), .NAME("adm76")) u_b (
        .clk(clk), .rst(rst), .scl_i(m_scl), .sda_i(bus_sda), .sda_t(sda_t_b), .scl_t(scl_t_b)
    );

    always @(negedge clk) begin
        if (!mon_en)       saw_low_a = 1'b0;
        else if (!sda_t_a) saw_low_a = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_rstart();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic xfer_bit(input logic b, output logic s);
        m_sda = b; tick(Q);
        m_scl = 1'b1; tick(Q);
        s = bus_sda; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
        xfer_bit(1'b1, ack);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, s);
            d[i] = s;
        end
        xfer_bit(nack, s);
        m_sda = 1'b1;
    endtask

    initial begin
        logic       ack;
        logic       b;
        logic [7:0] d;

        rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
        tick(4);
        chk("rst_sda_t_a", sda_t_a, 1'b1);
        chk("rst_scl_t_a", scl_t_a, 1'b1);
        chk("rst_sda_t_b", sda_t_b, 1'b1);
        chk("rst_scl_t_b", scl_t_b, 1'b1);
        chk("rst_state",   16'(u_a.r_state), 16'(ST_IDLE));
        rst = 1'b0;
        tick(4);

        // Address match / mismatch
        i2c_start(); wr_byte(8'h20, ack); chk("adr10_ack", ack, 1'b0); i2c_stop();
        mon_en = 1'b1;
        i2c_start(); wr_byte(8'h22, ack); chk("adr11_nack", ack, 1'b1); i2c_stop();
        chk("adr11_sda_quiet", saw_low_a, 1'b0);
        mon_en = 1'b0;

        // READ_VIN default
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'h88, ack); chk("vin_cmd_ack", ack, 1'b0);
        i2c_rstart(); wr_byte(8'h21, ack); chk("vin_radr_ack", ack, 1'b0);
        rd_byte(1'b0, d); chk("vin_lsb", d, 8'h00);
        rd_byte(1'b1, d); chk("vin_msb", d, 8'h0A);
        i2c_stop();

        // Write then read back an unused command
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'hD9, ack);
        wr_byte(8'h07, ack); chk("d9_wr0_ack", ack, 1'b0);
        wr_byte(8'h00, ack); chk("d9_wr1_ack", ack, 1'b0);
        i2c_stop();
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'hD9, ack);
        i2c_rstart(); wr_byte(8'h21, ack);
        rd_byte(1'b0, d); chk("d9_lsb", d, 8'h07);
        rd_byte(1'b1, d); chk("d9_msb", d, 8'h00);
        i2c_stop();

        // Read beyond the word wraps back to the LSB
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'h8D, ack);
        i2c_rstart(); wr_byte(8'h21, ack);
        rd_byte(1'b0, d); chk("temp_lsb", d, 8'h00);
        rd_byte(1'b0, d); chk("temp_msb", d, 8'h03);
        rd_byte(1'b1, d); chk("temp_wrap", d, 8'h00);
        i2c_stop();

        // ADM1176 conversion readout
        i2c_start(); wr_byte(8'h90, ack); chk("a76_wadr_ack", ack, 1'b0);
        wr_byte(8'h05, ack); chk("a76_cmd_ack", ack, 1'b0);
        i2c_rstart(); wr_byte(8'h91, ack); chk("a76_radr_ack", ack, 1'b0);
        rd_byte(1'b0, d); chk("a76_v_hi", d, 8'hA0);
        rd_byte(1'b0, d); chk("a76_i_hi", d, 8'h10);
        rd_byte(1'b0, d); chk("a76_lo", d, 8'h00);
        rd_byte(1'b1, d); chk("a76_pad", d, 8'hFF);
        i2c_stop();

        // STOP in the middle of a read byte (0xE1 = 1110_0001)
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'hD9, ack);
        wr_byte(8'hE1, ack); wr_byte(8'h00, ack); i2c_stop();
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'hD9, ack);
        i2c_rstart(); wr_byte(8'h21, ack);
        xfer_bit(1'b1, b); chk("mid_bit7", b, 1'b1);
        xfer_bit(1'b1, b); chk("mid_bit6", b, 1'b1);
        i2c_stop();
        tick(2);
        chk("mid_stop_state", 16'(u_a.r_state), 16'(ST_IDLE));
        chk("mid_stop_sda_t", sda_t_a, 1'b1);
        mon_en = 1'b1;
        for (int i = 0; i < 9; i++) xfer_bit(1'b1, b);
        chk("mid_stop_quiet", saw_low_a, 1'b0);
        mon_en = 1'b0;
        i2c_stop();
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'hD9, ack);
        i2c_rstart(); wr_byte(8'h21, ack);
        rd_byte(1'b1, d); chk("mid_recover", d, 8'hE1);
        i2c_stop();

        // Reset during the first data byte of a write
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'hD0, ack);
        xfer_bit(1'b0, b); xfer_bit(1'b1, b); xfer_bit(1'b0, b); xfer_bit(1'b1, b);
        rst = 1'b1; tick(2);
        chk("rst_mid_sda_t", sda_t_a, 1'b1);
        chk("rst_mid_state", 16'(u_a.r_state), 16'(ST_IDLE));
        rst = 1'b0;
        mon_en = 1'b1;
        xfer_bit(1'b1, b); xfer_bit(1'b0, b); xfer_bit(1'b1, b); xfer_bit(1'b0, b);
        xfer_bit(1'b1, ack);
        chk("rst_mid_no_ack", ack, 1'b1);
        chk("rst_mid_quiet", saw_low_a, 1'b0);
        mon_en = 1'b0;
        i2c_stop();
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'hD0, ack);
        i2c_rstart(); wr_byte(8'h21, ack);
        rd_byte(1'b0, d); chk("d0_lsb", d, 8'h00);
        rd_byte(1'b1, d); chk("d0_msb", d, 8'h00);
        i2c_stop();
        i2c_start(); wr_byte(8'h20, ack); wr_byte(8'h8C, ack);
        i2c_rstart(); wr_byte(8'h21, ack);
        rd_byte(1'b0, d); chk("iout_lsb", d, 8'h00);
        rd_byte(1'b1, d); chk("iout_msb", d, 8'h01);
        i2c_stop();

        tick(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
